// File: rtl/output_sampler_if.sv
// Sampling bus between the DUT-output tap, the output_sampler and the result writer.
interface output_sampler_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
);
    logic                    enable;
    logic                    clear;
    logic [DATA_WIDTH-1:0]   dut_outputs;
    logic [DATA_WIDTH-1:0]   sample_data;
    logic [31:0]             sample_index;
    logic                    sample_valid;
    logic                    sample_ready;
    logic                    sample_tick;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;

    modport master (
        output enable, clear, dut_outputs, sample_ready,
        input  sample_data, sample_index, sample_valid, sample_tick, fifo_count, overflow
    );

    modport slave (
        input  enable, clear, dut_outputs, sample_ready,
        output sample_data, sample_index, sample_valid, sample_tick, fifo_count, overflow
    );
endinterface

// File: rtl/output_sampler.sv
// Samples the DUT output bus at SAMPLE_FREQ via a drift-free phase accumulator into a FWFT FIFO.
// Define SAMPLER_TIMESTAMP_EN to store a 32-bit tick number with each sample.
module output_sampler #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DUT_CLK_FREQ = 100_000_000,
    parameter int unsigned SAMPLE_FREQ  = 1_000_000,
    parameter int unsigned DEPTH        = 16
) (
    input  logic            dut_clk,
    input  logic            reset,
    output_sampler_if.slave bus
);
    localparam int unsigned AccW = $clog2(DUT_CLK_FREQ) + 1;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
`ifdef SAMPLER_TIMESTAMP_EN
    localparam int unsigned EntryW = DATA_WIDTH + 32;
`else
    localparam int unsigned EntryW = DATA_WIDTH;
`endif
    localparam logic [AccW-1:0] Modulus = AccW'(DUT_CLK_FREQ);
    localparam logic [AccW-1:0] Step    = AccW'(SAMPLE_FREQ);
    localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
    localparam logic [0:0]      StIdle  = 1'b0;
    localparam logic [0:0]      StRun   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              run;
    logic [AccW-1:0]   acc_q, acc_d, acc_sum;
    logic              tick, push, pop, drop, full, empty;
    logic [EntryW-1:0] mem_q [DEPTH];
    logic [EntryW-1:0] entry_in, head;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.enable)  state_d = StRun;
            StRun:  if (!bus.enable) state_d = StIdle;
        endcase
    end

    // Tick is decided in the current cycle, so it follows the next state, not the registered one.
    assign run     = (state_d == StRun);
    assign acc_sum = acc_q + Step;
    assign tick    = run && (acc_sum >= Modulus);

    always_comb begin
        acc_d = acc_q;
        if (bus.clear)  acc_d = '0;
        else if (tick)  acc_d = acc_sum - Modulus;
        else if (run)   acc_d = acc_sum;
    end

    assign full  = (count_q == Full);
    assign empty = (count_q == '0);
    assign pop   = !empty && bus.sample_ready && !bus.clear;
    assign push  = tick && !bus.clear && (!full || pop);
    assign drop  = tick && !bus.clear && full && !pop;

    always_comb begin
        count_d = count_q;
        if (bus.clear)          count_d = '0;
        else if (push && !pop)  count_d = count_q + CntW'(1);
        else if (pop && !push)  count_d = count_q - CntW'(1);
    end

    always_ff @(posedge dut_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            if (bus.clear) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the read port is masked to zero whenever the FIFO is empty.
    always_ff @(posedge dut_clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end

    assign head = mem_q[rd_ptr_q];

`ifdef SAMPLER_TIMESTAMP_EN
    logic [31:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (bus.clear) tick_cnt_d = '0;
        else if (tick) tick_cnt_d = tick_cnt_q + 32'd1;
    end

    always_ff @(posedge dut_clk or posedge reset) begin
        if (reset) tick_cnt_q <= '0;
        else       tick_cnt_q <= tick_cnt_d;
    end

    assign entry_in         = {bus.dut_outputs, tick_cnt_q};
    assign bus.sample_data  = empty ? '0 : head[EntryW-1:32];
    assign bus.sample_index = empty ? '0 : head[31:0];
`else
    assign entry_in         = bus.dut_outputs;
    assign bus.sample_data  = empty ? '0 : head;
    assign bus.sample_index = '0;
`endif

    assign bus.sample_valid = !empty;
    assign bus.sample_tick  = tick;
    assign bus.fifo_count   = count_q;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_output_sampler.sv
// Directed bench for output_sampler: DUT A (25/100, DEPTH 4) and DUT B (30/100, DEPTH 16).
module tb_output_sampler;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    output_sampler_if #(.DATA_WIDTH(16), .DEPTH(4))  a_if ();
    output_sampler_if #(.DATA_WIDTH(16), .DEPTH(16)) b_if ();

    output_sampler #(
        .DATA_WIDTH(16), .DUT_CLK_FREQ(100), .SAMPLE_FREQ(25), .DEPTH(4)
    ) u_dut_a (
        .dut_clk (clk),
        .reset   (rst_a),
        .bus     (a_if.slave)
    );

    output_sampler #(
        .DATA_WIDTH(16), .DUT_CLK_FREQ(100), .SAMPLE_FREQ(30), .DEPTH(16)
    ) u_dut_b (
        .dut_clk (clk),
        .reset   (rst_b),
        .bus     (b_if.slave)
    );

    function automatic logic [31:0] exp_idx(input int n);
`ifdef SAMPLER_TIMESTAMP_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic reset_a();
        a_if.enable = 1'b0; a_if.clear = 1'b0; a_if.sample_ready = 1'b0; a_if.dut_outputs = '0;
        rst_a = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        a_if.enable = 1'b0; a_if.clear = 1'b0; a_if.sample_ready = 1'b0; a_if.dut_outputs = '0;
        b_if.enable = 1'b0; b_if.clear = 1'b0; b_if.sample_ready = 1'b0; b_if.dut_outputs = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        n_checks++;
        if ({a_if.sample_valid, a_if.sample_tick, a_if.overflow} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000",
                               {a_if.sample_valid, a_if.sample_tick, a_if.overflow});
        end
        n_checks++;
        if (a_if.fifo_count !== 3'd0 || a_if.sample_data !== 16'd0 || a_if.sample_index !== 32'd0)
        begin
            n_fail++; $display("FAIL reset_values got count=%0d data=%0d idx=%0d want 0/0/0",
                               a_if.fifo_count, a_if.sample_data, a_if.sample_index);
        end
        n_checks++;
        if (b_if.sample_valid !== 1'b0 || b_if.fifo_count !== 5'd0) begin
            n_fail++; $display("FAIL reset_b got valid=%b count=%0d want 0/0",
                               b_if.sample_valid, b_if.fifo_count);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_b = 1'b0;
    endtask

    task automatic test_basic();
        logic exp_tick;
        reset_a();
        a_if.enable = 1'b1; a_if.sample_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            a_if.dut_outputs = 16'(k);
            #1;
            exp_tick = (k % 4 == 3);
            n_checks++;
            if (a_if.sample_tick !== exp_tick) begin
                n_fail++; $display("FAIL basic_tick k=%0d got %b want %b", k, a_if.sample_tick, exp_tick);
            end
            if (k % 4 == 0 && k > 0) begin
                n_checks++;
                if (a_if.sample_valid !== 1'b1 || a_if.sample_data !== 16'(k - 1) ||
                    a_if.sample_index !== exp_idx(k / 4 - 1)) begin
                    n_fail++; $display("FAIL basic_sample k=%0d got v=%b d=%0d i=%0d want 1/%0d/%0d",
                        k, a_if.sample_valid, a_if.sample_data, a_if.sample_index, k - 1,
                        exp_idx(k / 4 - 1));
                end
            end
            @(posedge clk); #1;
        end
        a_if.enable = 1'b0;
    endtask

    task automatic test_rate();
        int ticks = 0;
        int last  = -1;
        int bad   = 0;
        b_if.enable = 1'b1; b_if.sample_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            b_if.dut_outputs = 16'(k);
            #1;
            if (b_if.sample_tick === 1'b1) begin
                ticks++;
                if (last >= 0 && (k - last) != 3 && (k - last) != 4) bad++;
                last = k;
            end
            @(posedge clk); #1;
        end
        b_if.enable = 1'b0;
        n_checks++;
        if (ticks != 30) begin
            n_fail++; $display("FAIL rate_count got %0d want 30", ticks);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rate_spacing got %0d bad gaps want 0", bad);
        end
    endtask

    task automatic test_overflow();
        reset_a();
        a_if.enable = 1'b1;
        for (int k = 0; k < 29; k++) begin
            a_if.dut_outputs  = 16'(k);
            a_if.sample_ready = (k >= 24);
            #1;
            if (k == 16 || k == 20 || k == 24) begin
                n_checks++;
                if (a_if.fifo_count !== 3'd4 || a_if.overflow !== (k != 16)) begin
                    n_fail++; $display("FAIL ovf_state k=%0d got count=%0d ovf=%b want 4/%b",
                                       k, a_if.fifo_count, a_if.overflow, k != 16);
                end
            end
            if (k >= 24 && k <= 27) begin
                n_checks++;
                if (a_if.sample_data !== 16'(3 + 4 * (k - 24)) ||
                    a_if.sample_index !== exp_idx(k - 24)) begin
                    n_fail++; $display("FAIL ovf_drain k=%0d got d=%0d i=%0d want %0d/%0d",
                        k, a_if.sample_data, a_if.sample_index, 3 + 4 * (k - 24), exp_idx(k - 24));
                end
            end
            if (k == 28) begin
                n_checks++;
                if (a_if.sample_valid !== 1'b1 || a_if.sample_data !== 16'd27 ||
                    a_if.sample_index !== exp_idx(6)) begin
                    n_fail++; $display("FAIL ovf_gap got v=%b d=%0d i=%0d want 1/27/%0d",
                        a_if.sample_valid, a_if.sample_data, a_if.sample_index, exp_idx(6));
                end
            end
            @(posedge clk); #1;
        end
        a_if.enable = 1'b0;
    endtask

    task automatic test_full_pop();
        reset_a();
        a_if.enable = 1'b1;
        for (int k = 0; k < 24; k++) begin
            a_if.dut_outputs  = 16'(k);
            a_if.sample_ready = (k >= 19);
            #1;
            if (k == 20) begin
                n_checks++;
                if (a_if.fifo_count !== 3'd4 || a_if.overflow !== 1'b0) begin
                    n_fail++; $display("FAIL fullpop_count got count=%0d ovf=%b want 4/0",
                                       a_if.fifo_count, a_if.overflow);
                end
            end
            if (k >= 20) begin
                n_checks++;
                if (a_if.sample_data !== 16'(7 + 4 * (k - 20)) ||
                    a_if.sample_index !== exp_idx(k - 19)) begin
                    n_fail++; $display("FAIL fullpop_data k=%0d got d=%0d i=%0d want %0d/%0d",
                        k, a_if.sample_data, a_if.sample_index, 7 + 4 * (k - 20), exp_idx(k - 19));
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (a_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL fullpop_ovf got %b want 0", a_if.overflow);
        end
        a_if.enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset_a();
        a_if.enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            a_if.dut_outputs = 16'(k);
            @(posedge clk); #1;
        end
        #1;
        n_checks++;
        if (a_if.fifo_count !== 3'd3) begin
            n_fail++; $display("FAIL rstmid_pre got count=%0d want 3", a_if.fifo_count);
        end
        rst_a = 1'b1;
        #1;
        n_checks++;
        if (a_if.sample_valid !== 1'b0 || a_if.fifo_count !== 3'd0 || a_if.sample_data !== 16'd0)
        begin
            n_fail++; $display("FAIL rstmid_async got v=%b count=%0d d=%0d want 0/0/0",
                               a_if.sample_valid, a_if.fifo_count, a_if.sample_data);
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_if.dut_outputs = 16'(k);
            #1;
            n_checks++;
            if (a_if.sample_tick !== (k == 3)) begin
                n_fail++; $display("FAIL rstmid_tick k=%0d got %b want %b", k, a_if.sample_tick, k == 3);
            end
            if (k == 4) begin
                n_checks++;
                if (a_if.sample_valid !== 1'b1 || a_if.sample_data !== 16'd3 ||
                    a_if.sample_index !== exp_idx(0)) begin
                    n_fail++; $display("FAIL rstmid_first got v=%b d=%0d i=%0d want 1/3/0",
                        a_if.sample_valid, a_if.sample_data, a_if.sample_index);
                end
            end
            @(posedge clk); #1;
        end
        a_if.enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        reset_a();
        for (int k = 0; k < 18; k++) begin
            a_if.dut_outputs  = 16'(k);
            a_if.enable       = (k < 10 || k >= 15);
            a_if.sample_ready = (k >= 12);
            #1;
            n_checks++;
            if (a_if.sample_tick !== (k == 3 || k == 7 || k == 16)) begin
                n_fail++; $display("FAIL endrop_tick k=%0d got %b want %b",
                                   k, a_if.sample_tick, (k == 3 || k == 7 || k == 16));
            end
            if (k == 10) begin
                n_checks++;
                if (a_if.fifo_count !== 3'd2) begin
                    n_fail++; $display("FAIL endrop_queued got %0d want 2", a_if.fifo_count);
                end
            end
            if (k == 12 || k == 13) begin
                n_checks++;
                if (a_if.sample_valid !== 1'b1 || a_if.sample_data !== 16'(k == 12 ? 3 : 7) ||
                    a_if.sample_index !== exp_idx(k - 12)) begin
                    n_fail++; $display("FAIL endrop_drain k=%0d got v=%b d=%0d i=%0d",
                        k, a_if.sample_valid, a_if.sample_data, a_if.sample_index);
                end
            end
            if (k == 14) begin
                n_checks++;
                if (a_if.sample_valid !== 1'b0 || a_if.fifo_count !== 3'd0) begin
                    n_fail++; $display("FAIL endrop_empty got v=%b count=%0d want 0/0",
                                       a_if.sample_valid, a_if.fifo_count);
                end
            end
            if (k == 17) begin
                n_checks++;
                if (a_if.sample_data !== 16'd16 || a_if.sample_index !== exp_idx(2)) begin
                    n_fail++; $display("FAIL endrop_resume got d=%0d i=%0d want 16/%0d",
                        a_if.sample_data, a_if.sample_index, exp_idx(2));
                end
            end
            @(posedge clk); #1;
        end
        a_if.enable = 1'b0;
    endtask

    task automatic test_clear();
        reset_a();
        for (int k = 0; k < 27; k++) begin
            a_if.dut_outputs  = 16'(k);
            a_if.enable       = (k != 21);
            a_if.sample_ready = (k == 20 || k == 21);
            a_if.clear        = (k == 21);
            #1;
            if (k == 20) begin
                n_checks++;
                if (a_if.fifo_count !== 3'd4 || a_if.overflow !== 1'b1) begin
                    n_fail++; $display("FAIL clear_pre got count=%0d ovf=%b want 4/1",
                                       a_if.fifo_count, a_if.overflow);
                end
            end
            if (k == 21) begin
                n_checks++;
                if (a_if.fifo_count !== 3'd3) begin
                    n_fail++; $display("FAIL clear_drain got count=%0d want 3", a_if.fifo_count);
                end
            end
            if (k == 22) begin
                n_checks++;
                if (a_if.fifo_count !== 3'd0 || a_if.overflow !== 1'b0 || a_if.sample_valid !== 1'b0)
                begin
                    n_fail++; $display("FAIL clear_post got count=%0d ovf=%b v=%b want 0/0/0",
                                       a_if.fifo_count, a_if.overflow, a_if.sample_valid);
                end
            end
            if (k == 24 || k == 25) begin
                n_checks++;
                if (a_if.sample_tick !== (k == 25)) begin
                    n_fail++; $display("FAIL clear_acc k=%0d got %b want %b", k, a_if.sample_tick, k == 25);
                end
            end
            if (k == 26) begin
                n_checks++;
                if (a_if.sample_data !== 16'd25 || a_if.sample_index !== exp_idx(0)) begin
                    n_fail++; $display("FAIL clear_index got d=%0d i=%0d want 25/0",
                                       a_if.sample_data, a_if.sample_index);
                end
            end
            @(posedge clk); #1;
        end
        a_if.enable = 1'b0; a_if.clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rate();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_enable_drop();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/output_sampler.md
# output_sampler

Downstream stage of the testbench interface: samples the DUT output bus at the configured sample rate, derived from the DUT clock by a phase accumulator. Samples are buffered in a small FIFO and handed to the result writer over a valid/ready handshake. Sits between the interface's DUT-output signals and the file-writing object, decoupling writer back-pressure from the sample rate.

## Interface
- DATA_WIDTH, 16, width of the sampled DUT output bus
- DUT_CLK_FREQ, 100_000_000, DUT clock frequency in Hz (accumulator modulus)
- SAMPLE_FREQ, 1_000_000, sample rate in Hz; 1 ≤ SAMPLE_FREQ ≤ DUT_CLK_FREQ
- DEPTH, 16, FIFO entries; power of two, ≥ 2

Ports:
- dut_clk  in  1  sole clock, rising-edge active
- reset  in  1  asynchronous, active-high
- enable  in  1  sample ticks are generated only while high
- clear  in  1  synchronous: flushes FIFO, zeroes accumulator, sample counter and overflow
- dut_outputs  in  DATA_WIDTH  DUT output bus to sample
- sample_data  out  DATA_WIDTH  head-of-FIFO sample
- sample_index  out  32  tick number of head sample (see Configuration)
- sample_valid  out  1  head entry present
- sample_ready  in  1  writer accepts head entry
- sample_tick  out  1  one-cycle pulse on each sample instant
- fifo_count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: a sample was dropped while full

## Operation
- Accumulator `acc` has width $clog2(DUT_CLK_FREQ)+1; reset value 0. Each cycle with enable=1: if acc+SAMPLE_FREQ ≥ DUT_CLK_FREQ, then sample_tick=1 and acc ← acc+SAMPLE_FREQ−DUT_CLK_FREQ; otherwise acc ← acc+SAMPLE_FREQ. With enable=0, acc holds and sample_tick=0.
- Tick count over any DUT_CLK_FREQ enabled cycles equals exactly SAMPLE_FREQ. No drift.
- On tick: push {dut_outputs, tick_counter} into the FIFO. tick_counter then increments, wrapping 2^32−1 → 0.
- Pop occurs when sample_valid && sample_ready.
- Push while full:
  - with a pop in the same cycle, the push is accepted and the count is unchanged;
  - without a pop, the sample is dropped, overflow ← 1, and tick_counter still increments, so the gap is visible in sample_index.
- FIFO is first-word-fall-through. sample_data and sample_index are stable while sample_valid=1 && sample_ready=0.
- clear has priority over push and pop in the same cycle.
- Controller states:
  - IDLE: enable=0, FIFO may still drain.
  - RUN: enable=1.
  - IDLE→RUN on enable rise. RUN→IDLE on enable fall.
  - Draining continues in IDLE.

## Timing
- All outputs reset to 0: sample_data, sample_index, sample_valid, sample_tick, fifo_count, overflow, and the internal acc and tick_counter.
- Reset mid-operation discards FIFO contents immediately (asynchronous). The first tick after release follows the accumulator rule from acc=0.
- sample_tick is combinational from the registered acc and enable. Sample is captured at the same rising edge.
- Latency from tick cycle N to sample_valid with an empty FIFO: asserted in cycle N+1.
- fifo_count updates on the edge after push/pop.
- overflow sets on the edge of the dropping tick. It clears only on reset or clear.

## Configuration
- SAMPLER_TIMESTAMP_EN defined:
  - FIFO entries are DATA_WIDTH+32 bits;
  - sample_index carries the tick number of the head sample.
- SAMPLER_TIMESTAMP_EN undefined:
  - entries are DATA_WIDTH bits;
  - tick_counter is not instantiated;
  - sample_index is tied to 0.
- All other behaviour is identical.

## Test plan
- DUT_CLK_FREQ=100, SAMPLE_FREQ=25, enable=1, dut_outputs=cycle number, sample_ready=1 → tick every 4th cycle (cycles 3, 7, 11, …); samples 3, 7, 11; sample_index 0, 1, 2.
- DUT_CLK_FREQ=100, SAMPLE_FREQ=30, run 100 cycles → exactly 30 ticks; tick spacing only 3 or 4 cycles.
- DEPTH=4, sample_ready=0, 6 ticks → fifo_count=4 and overflow=1 after 5th tick. Release ready → indices 0..3 delivered, then next accepted sample has index 6 (timestamp build).
- Full FIFO, tick coinciding with pop → fifo_count stays 4, overflow stays 0, new sample appended.
- Reset asserted mid-stream with 3 entries → sample_valid=0 and fifo_count=0 immediately, without a clock edge. After release with SAMPLE_FREQ=25, first tick on 4th enabled cycle with index 0.
- enable dropped with 2 entries queued → no further ticks; both entries drain; clear during drain → fifo_count=0 next cycle, overflow=0.
